// File: rtl/tdm_demux4.sv
// 4-channel bit-interleaved TDM receiver: slots serial bits into per-channel
// LSB-first words and tracks frame alignment against a frame-sync marker.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic [WIDTH-1:0] ch2_data,
  output logic [WIDTH-1:0] ch3_data,
  output logic [3:0]       ch_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int unsigned FRAME_LEN = 4 * WIDTH;
  localparam int unsigned POS_W     = $clog2(FRAME_LEN);
  localparam int unsigned IDX_W     = POS_W - 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [WIDTH-1:0]   sr_q   [4];
  logic [WIDTH-1:0]   sr_d   [4];
  logic [WIDTH-1:0]   data_q [4];
  logic [WIDTH-1:0]   data_d [4];
  logic [3:0]         valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;

  logic [1:0]         slot;
  logic [IDX_W-1:0]   bit_idx;
  logic [WIDTH-1:0]   shifted;
  logic               word_done;
  logic               pos_last;

  assign slot      = pos_q[1:0];
  assign bit_idx   = pos_q[POS_W-1:2];
  assign shifted   = {din, sr_q[slot][WIDTH-1:1]};
  assign word_done = (bit_idx == IDX_W'(WIDTH - 1));
  assign pos_last  = (pos_q == POS_W'(FRAME_LEN - 1));

  // Next-state: alignment tracking, slot routing and word completion
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 4'b0000;
    err_d   = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            for (int c = 0; c < 4; c++) sr_d[c] = '0;
            sr_d[0] = {din, {(WIDTH-1){1'b0}}};
            pos_d   = POS_W'(1);
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync && (pos_q != '0)) begin
            // Early sync restarts the frame; partial words are dropped
            err_d = 1'b1;
            for (int c = 0; c < 4; c++) sr_d[c] = '0;
            sr_d[0] = {din, {(WIDTH-1){1'b0}}};
            pos_d   = POS_W'(1);
          end else if (!frame_sync && (pos_q == '0)) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            sr_d[slot] = shifted;
            if (word_done) begin
              data_d[slot]  = shifted;
              valid_d[slot] = 1'b1;
            end
            pos_d = pos_last ? '0 : pos_q + POS_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      pos_q    <= '0;
      valid_q  <= 4'b0000;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        sr_q[c]   <= '0;
        data_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      for (int c = 0; c < 4; c++) begin
        sr_q[c]   <= sr_d[c];
        data_q[c] <= data_d[c];
      end
    end
  end

  assign ch0_data = data_q[0];
  assign ch1_data = data_q[1];
  assign ch2_data = data_q[2];
  assign ch3_data = data_q[3];
  assign ch_valid = valid_q;
  assign locked   = locked_q;
  assign sync_err = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=8): frame vectors built from known
// channel words, plus a hand sequence for the asynchronous mid-frame reset.
module tb_tdm_demux4;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] ch0_data, ch1_data, ch2_data, ch3_data;
  logic [3:0]       ch_valid;
  logic             locked;
  logic             sync_err;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch0_data   (ch0_data),
    .ch1_data   (ch1_data),
    .ch2_data   (ch2_data),
    .ch3_data   (ch3_data),
    .ch_valid   (ch_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             dv;
    logic             fs;
    logic             din;
    logic [3:0]       ev;
    logic             el;
    logic             ee;
    logic [3:0][7:0]  ed;
  } vec_t;

  vec_t            vecs[$];
  logic [3:0][7:0] exp_data;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] ev, input logic el,
                             input logic ee, input logic [3:0][7:0] ed);
    chk({tag, " ch_valid"}, 32'(ch_valid), 32'(ev));
    chk({tag, " locked"},   32'(locked),   32'(el));
    chk({tag, " sync_err"}, 32'(sync_err), 32'(ee));
    chk({tag, " data"},     {ch3_data, ch2_data, ch1_data, ch0_data}, ed);
  endtask

  // Idle cycle: frame_sync deliberately high to show it is ignored without din_valid
  task automatic add_idle(input logic el);
    vec_t v;
    v.dv = 1'b0; v.fs = 1'b1; v.din = 1'($urandom_range(0, 1));
    v.ev = 4'b0000; v.el = el; v.ee = 1'b0; v.ed = exp_data;
    vecs.push_back(v);
  endtask

  // Append nbits of a frame carrying words w; decode=0 means the DUT should be hunting
  task automatic add_frame(input logic [3:0][7:0] w, input bit sync_first, input bit err_first,
                           input bit decode, input int nbits, input logic [31:0] idle_mask);
    vec_t v;
    for (int p = 0; p < nbits; p++) begin
      if (idle_mask[p]) add_idle(decode);
      v.dv  = 1'b1;
      v.fs  = sync_first && (p == 0);
      v.din = w[p % 4][p / 4];
      v.ev  = 4'b0000;
      if (decode && p >= 28) begin
        exp_data[p - 28] = w[p - 28];
        v.ev = 4'(1 << (p - 28));
      end
      v.el = decode;
      v.ee = err_first && (p == 0);
      v.ed = exp_data;
      vecs.push_back(v);
    end
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      din_valid  = vecs[i].dv;
      frame_sync = vecs[i].fs;
      din        = vecs[i].din;
      @(posedge clk);
      #1;
      chk_outputs($sformatf("%s[%0d]", tag, i), vecs[i].ev, vecs[i].el, vecs[i].ee, vecs[i].ed);
    end
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    vecs.delete();
  endtask

  localparam logic [3:0][7:0] W_A = {8'h01, 8'hFF, 8'h3C, 8'hA5};
  localparam logic [3:0][7:0] W_B = {8'h78, 8'h56, 8'h34, 8'h12};
  localparam logic [3:0][7:0] W_C = {8'hF0, 8'hDE, 8'hBC, 8'h9A};
  localparam logic [3:0][7:0] W_D = {8'h11, 8'h22, 8'h44, 8'h88};
  localparam logic [3:0][7:0] W_E = {8'hC3, 8'h5A, 8'h0F, 8'h96};
  localparam logic [3:0][7:0] W_F = {8'h7E, 8'h81, 8'h24, 8'hE7};

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    exp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", 4'b0000, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;

    // HUNT ignores unsynced bits before the first frame
    add_frame(W_D, 1'b0, 1'b0, 1'b0, 5, 32'h0);
    // Aligned frame, then the same frame with idle gaps, then back-to-back frames
    add_frame(W_A, 1'b1, 1'b0, 1'b1, 32, 32'h0);
    add_frame(W_A, 1'b1, 1'b0, 1'b1, 32, 32'h2002_0040);
    add_frame(W_A, 1'b1, 1'b0, 1'b1, 32, 32'h0);
    add_frame(W_B, 1'b1, 1'b0, 1'b1, 32, 32'h0);
    // Missing sync drops lock, rest of that frame ignored, then relock
    add_frame(W_A, 1'b0, 1'b1, 1'b0, 32, 32'h0000_0100);
    add_frame(W_C, 1'b1, 1'b0, 1'b1, 32, 32'h0);
    // Early sync at pos 13 discards the partial frame
    add_frame(W_D, 1'b1, 1'b0, 1'b1, 13, 32'h0);
    add_frame(W_E, 1'b1, 1'b1, 1'b1, 32, 32'h0);
    // Early sync on the bit that would complete ch0: sync wins, no ch_valid
    add_frame(W_D, 1'b1, 1'b0, 1'b1, 28, 32'h0);
    add_frame(W_C, 1'b1, 1'b1, 1'b1, 32, 32'h0);
    run_vecs("seq");

    // Async reset between edges at pos 20
    add_frame(W_F, 1'b1, 1'b0, 1'b1, 20, 32'h0);
    run_vecs("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk_outputs("async_rst", 4'b0000, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    chk_outputs("rst_held", 4'b0000, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    exp_data = '0;

    add_idle(1'b0);
    add_frame(W_F, 1'b1, 1'b0, 1'b1, 32, 32'h0);
    run_vecs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Time-division demultiplexer: the receive end of a 4-channel bit-interleaved serial link, and the counterpart of the 4:1 selector used in the shifter datapath.
- Takes one serial bit per valid cycle.
- Routes each bit to one of four channels by slot position.
- Deserializes each channel into a WIDTH-bit word.
- Tracks frame alignment against a frame-sync marker.
- Sits between the serial link front-end and the per-channel parallel consumers.

Parameters:
WIDTH, 8, bits per channel word; legal range 2..16.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
din  input  1  serial data bit.
din_valid  input  1  din is valid this cycle; bit is accepted on this edge.
frame_sync  input  1  qualified by din_valid; marks the first bit of a frame.
ch0_data  output  WIDTH  last completed word for channel 0.
ch1_data  output  WIDTH  last completed word for channel 1.
ch2_data  output  WIDTH  last completed word for channel 2.
ch3_data  output  WIDTH  last completed word for channel 3.
ch_valid  output  4  one-cycle pulse per channel when its word completes (bit c = channel c).
locked  output  1  high while in the LOCKED state.
sync_err  output  1  one-cycle pulse on an alignment error.

Behaviour:
- Reset (async, rst=1): all four chN_data = 0, ch_valid = 0, locked = 0, sync_err = 0, position counter = 0, shift registers = 0, state = HUNT.
- Frame layout:
  - Frame length is 4*WIDTH accepted bits.
  - Position counter pos runs 0..4*WIDTH-1 with explicit wrap to 0; it advances only on accepted bits.
  - slot = pos mod 4; bit index = pos div 4.
  - The bit at pos goes to channel slot, at bit index (LSB first).
- Accepted bit means din_valid=1 at the clock edge. Cycles with din_valid=0 change no state, and ch_valid and sync_err are 0 in those cycles.
- State HUNT:
  - Bits are ignored unless frame_sync=1.
  - An accepted bit with frame_sync=1 is stored as pos 0 (ch0 bit0), pos becomes 1, and the state moves to LOCKED.
- State LOCKED:
  - Each accepted bit is shifted into the shift register of its slot.
  - When the bit index is WIDTH-1, chN_data for that slot loads the complete word, including the current bit, on the same edge. ch_valid[slot] is high for the following cycle only. Latency from last bit accepted to data/valid is 1 cycle.
  - Channels therefore complete on consecutive accepted bits at pos 4*WIDTH-4 .. 4*WIDTH-1.
  - chN_data holds its value until the next completion for that channel.
- Sync checking, LOCKED only:
  - frame_sync=1 on an accepted bit at pos != 0 (early sync):
    - sync_err pulses.
    - All partial shift registers are cleared.
    - No ch_valid is issued for the discarded partial words.
    - The bit is taken as pos 0 of a new frame (pos becomes 1).
    - The state stays LOCKED.
  - frame_sync=0 on an accepted bit at pos 0 (missing sync):
    - sync_err pulses.
    - The state moves to HUNT and the bit is discarded.
    - chN_data keep their last values.
  - frame_sync=1 at pos 0 is normal; no error.
- Simultaneous events:
  - At pos 4*WIDTH-1 the ch3 completion and the wrap to 0 happen on the same edge.
  - An early sync arriving on a bit that would complete a word: the sync wins, the word is discarded, and that ch_valid is not asserted.
- Reset asserted mid-frame clears everything immediately, independent of clk. Operation resumes in HUNT.

Test Plan:
1. WIDTH=8, reset, then one aligned frame (frame_sync on the first bit, 32 bits) carrying ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x01 interleaved LSB first -> locked=1 after the first bit; ch_valid = 0001, 0010, 0100, 1000 on the 4 cycles after bits 28..31; data values as sent; sync_err never high.
2. Same frame with din_valid deasserted for 3 random cycles between bits -> identical words and valid order; no output changes during idle cycles.
3. Two back-to-back frames (0xA5,0x3C,0xFF,0x01 then 0x12,0x34,0x56,0x78), sync on each first bit -> 8 ch_valid pulses with correct words; locked stays 1.
4. Second frame sent without frame_sync on its first bit -> sync_err pulses once; locked drops to 0; chN_data keep frame-1 values; subsequent bits without sync are ignored; a following synced frame relocks and delivers correctly.
5. frame_sync asserted at pos 13 mid-frame -> sync_err pulse; no ch_valid for that frame; next 32 bits decode as a fresh frame with correct words.
6. rst pulsed asynchronously (between clock edges) at pos 20 -> all outputs 0 immediately; locked=0; a new synced frame decodes correctly.
